pwm_cmd_sequencer: RTL and testbench
====================================

// Module: pwm_cmd_sequencer
// PURPOSE
//  Sits between the SPI frame receiver and the PWM/clock-divider bank. Queues 16-bit
//  command words, decodes them and issues single-cycle write strobes plus write data
//  to 8 PWM channels and the clock divider. Supports broadcast writes and an optional
//  sync mode that holds compare updates until a PWM period boundary.
// PARAMETERS
//  NUM_CH      8   PWM channels driven (one-hot pwm_wr width)
//  CMP_W       10  compare value width, taken from cmd_data[CMP_W-1:0]
//  DIV_W       4   clock-divider value width, taken from cmd_data[DIV_W-1:0]
//  FIFO_DEPTH  4   command queue entries (power of two)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-high reset
//  cmd_data     in   16      command word: [15:12] addr, [11:0] payload
//  cmd_valid    in   1       level valid from SPI receiver; one command per rising edge
//  period_tick  in   1       1-cycle pulse at PWM period wrap (used in sync mode)
//  pwm_wr       out  NUM_CH  one-hot channel write strobe, 1 cycle
//  pwm_compare  out  CMP_W   compare data, valid while pwm_wr != 0
//  clk_div_wr   out  1       clock-divider write strobe, 1 cycle
//  clk_div_in   out  DIV_W   divider data, valid while clk_div_wr = 1
//  sync_mode    out  1       current config bit
//  busy         out  1       FIFO non-empty or FSM not IDLE
//  cmd_drop     out  1       1-cycle pulse: command lost, FIFO full
//  cmd_err      out  1       1-cycle pulse: undefined address popped
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, sync_mode 0, bcast counter 0.
//  Push: cmd_valid & ~cmd_valid_q (registered prior sample) pushes cmd_data that cycle.
//   Full and no pop that cycle -> word discarded, cmd_drop=1 next cycle.
//   Full with simultaneous pop -> push accepted. Holding cmd_valid high pushes nothing more.
//  Address decode (on pop):
//   0x0-0x7  write ch[addr] (addr>=NUM_CH -> cmd_err); 0x8 divider write;
//   0x9  broadcast compare to ch 0..NUM_CH-1; 0xA sync_mode<=payload[0];
//   0xB-0xF  cmd_err, no strobe.
//  FSM states IDLE, ISSUE, BCAST, WAIT_TICK. Pop only in IDLE with FIFO non-empty;
//   popped word is latched in cur register.
//   IDLE->ISSUE: addr 0x0-0x8, or 0x9 with sync_mode=0 -> BCAST directly.
//   IDLE->WAIT_TICK: channel/broadcast write with sync_mode=1.
//   IDLE->IDLE: 0xA applied same cycle as pop; errors pulse cmd_err next cycle.
//   WAIT_TICK: period_tick=1 -> ISSUE (single ch) or BCAST. Divider/config never wait.
//   ISSUE: registered strobe+data for exactly 1 cycle, -> IDLE.
//   BCAST: strobe pwm_wr[i], i=0..NUM_CH-1, one per cycle, same data; -> IDLE after last.
//  Latency, empty FIFO, sync off: cmd_valid rises cycle N -> strobe high cycle N+3
//   (push N, pop N+1, ISSUE N+2, registered output N+3). Back-to-back throughput:
//   one single write per 2 cycles; broadcast occupies NUM_CH+1 cycles.
//  Never more than one strobe bit high; pwm_wr and clk_div_wr never together.
//  sync_mode change affects only commands popped after it; a word in WAIT_TICK keeps waiting.
//  Reset mid-broadcast or mid-wait: abort immediately, strobes drop to 0, queue lost.
//  FIFO pointers wrap modulo FIFO_DEPTH with extra MSB for full/empty.
// STRUCTURE
//  Shared package pwm_pkg: addr constants ADDR_CH_MAX=4'h7, ADDR_CLKDIV=4'h8,
//   ADDR_BCAST=4'h9, ADDR_CFG=4'hA; FSM state encoding; CMD_W=16.
//  One sub-module: cmd_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty).
//  Decode, FSM, broadcast counter and output registers in this module.
// TESTING
//  1 Reset, cmd 0x3155 one rising edge -> pwm_wr=8'h08, pwm_compare=10'h155, 1 cycle at N+3.
//  2 cmd 0x8007 -> clk_div_wr=1, clk_div_in=4'h7, 1 cycle; pwm_wr stays 0.
//  3 cmd 0x9200 -> pwm_wr 01,02,04..80 on 8 consecutive cycles, compare 10'h200; busy then 0.
//  4 cmd 0xA001 then 0x1010 -> no strobe until period_tick pulse; pwm_wr=8'h02 1 cycle later.
//  5 6 cmds while FSM stalled in WAIT_TICK -> 5th pops? no: 4 queued, 6th gives cmd_drop;
//    queued 4 issue in order after tick. cmd 0xF000 -> cmd_err pulse, no strobe.
//  6 Assert rst during broadcast at ch 3 -> all outputs 0 async; post-reset cmd works normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM command sequencer: command word layout,
// address map and the sequencer FSM state encoding.
package pwm_pkg;

  localparam int CMD_W     = 16;
  localparam int ADDR_W    = 4;
  localparam int PAYLOAD_W = CMD_W - ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_CH_MAX = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_CLKDIV = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_BCAST  = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_CFG    = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_BCAST     = 2'd2,
    ST_WAIT_TICK = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_cmd_sequencer_if.sv
// Command-side and strobe-side signals of the sequencer. The master is the
// SPI receiver / timing side, the slave is the sequencer itself.
interface pwm_cmd_sequencer_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CMP_W  = 10,
  parameter int DIV_W  = 4
);

  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_valid;
  logic              period_tick;
  logic [NUM_CH-1:0] pwm_wr;
  logic [CMP_W-1:0]  pwm_compare;
  logic              clk_div_wr;
  logic [DIV_W-1:0]  clk_div_in;
  logic              sync_mode;
  logic              busy;
  logic              cmd_drop;
  logic              cmd_err;

  modport master (
    output cmd_data, cmd_valid, period_tick,
    input  pwm_wr, pwm_compare, clk_div_wr, clk_div_in,
           sync_mode, busy, cmd_drop, cmd_err
  );

  modport slave (
    input  cmd_data, cmd_valid, period_tick,
    output pwm_wr, pwm_compare, clk_div_wr, clk_div_in,
           sync_mode, busy, cmd_drop, cmd_err
  );

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous first-word-fall-through FIFO for command words.
// Pointers carry one extra MSB so full and empty can be told apart.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full queue still lands when the same cycle frees a slot.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pwm_cmd_sequencer.sv
// Queues SPI command words, decodes them and issues single-cycle write
// strobes to the PWM channel bank and the clock divider, with broadcast
// writes and an optional hold-until-period-boundary mode.
module pwm_cmd_sequencer
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CMP_W      = 10,
  parameter int DIV_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  pwm_cmd_sequencer_if.slave bus
);

  localparam int BCNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state;
  state_t              state_nxt;
  logic                cmd_valid_q;
  logic                push_req;
  logic                pop;
  logic                pop_err;
  logic                cfg_wr;
  logic [ADDR_W-1:0]   pop_addr;
  logic [CMD_W-1:0]    fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W-1:0]   cur_addr;
  logic [PAYLOAD_W-1:0] cur_payload;
  logic [BCNT_W-1:0]   bcnt;
  logic                sync_q;
  logic                err_q;
  logic                drop_q;
  logic [NUM_CH-1:0]   pwm_wr_q;
  logic [NUM_CH-1:0]   pwm_wr_nxt;
  logic [CMP_W-1:0]    cmp_q;
  logic [CMP_W-1:0]    cmp_nxt;
  logic                div_wr_q;
  logic                div_wr_nxt;
  logic [DIV_W-1:0]    div_in_q;
  logic [DIV_W-1:0]    div_in_nxt;
  logic [NUM_CH-1:0]   one_hot_base;
  logic                unused_payload;

  assign one_hot_base   = {{(NUM_CH-1){1'b0}}, 1'b1};
  assign push_req       = bus.cmd_valid & ~cmd_valid_q;
  assign pop_addr       = fifo_dout[CMD_W-1:PAYLOAD_W];
  assign unused_payload = ^cur_payload;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (bus.cmd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register; reset aborts any broadcast or pending wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and pop decode: the head word is decoded as it is popped.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pop_err   = 1'b0;
    cfg_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (pop_addr <= ADDR_CH_MAX) begin
            if (int'(pop_addr) < NUM_CH) state_nxt = sync_q ? ST_WAIT_TICK : ST_ISSUE;
            else                         pop_err   = 1'b1;
          end else if (pop_addr == ADDR_CLKDIV) begin
            state_nxt = ST_ISSUE;
          end else if (pop_addr == ADDR_BCAST) begin
            state_nxt = sync_q ? ST_WAIT_TICK : ST_BCAST;
          end else if (pop_addr == ADDR_CFG) begin
            cfg_wr = 1'b1;
          end else begin
            pop_err = 1'b1;
          end
        end
      end
      ST_WAIT_TICK: begin
        if (bus.period_tick) state_nxt = (cur_addr == ADDR_BCAST) ? ST_BCAST : ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_IDLE;
      ST_BCAST: begin
        if (bcnt == BCNT_W'(NUM_CH-1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobe/data values to be registered this cycle, derived from the state.
  always_comb begin
    pwm_wr_nxt = '0;
    cmp_nxt    = '0;
    div_wr_nxt = 1'b0;
    div_in_nxt = '0;
    case (state)
      ST_ISSUE: begin
        if (cur_addr == ADDR_CLKDIV) begin
          div_wr_nxt = 1'b1;
          div_in_nxt = cur_payload[DIV_W-1:0];
        end else begin
          pwm_wr_nxt = one_hot_base << cur_addr;
          cmp_nxt    = cur_payload[CMP_W-1:0];
        end
      end
      ST_BCAST: begin
        pwm_wr_nxt = one_hot_base << bcnt;
        cmp_nxt    = cur_payload[CMP_W-1:0];
      end
      default: ;
    endcase
  end

  // Datapath: edge detect, current command latch, broadcast counter,
  // config bit, status pulses and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cur_addr    <= '0;
      cur_payload <= '0;
      bcnt        <= '0;
      sync_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      pwm_wr_q    <= '0;
      cmp_q       <= '0;
      div_wr_q    <= 1'b0;
      div_in_q    <= '0;
    end else begin
      cmd_valid_q <= bus.cmd_valid;
      drop_q      <= push_req & fifo_full & ~pop;
      err_q       <= pop_err;
      if (pop) begin
        cur_addr    <= pop_addr;
        cur_payload <= fifo_dout[PAYLOAD_W-1:0];
        bcnt        <= '0;
      end else if (state == ST_BCAST) begin
        bcnt <= bcnt + BCNT_W'(1);
      end
      if (cfg_wr) sync_q <= fifo_dout[0];
      pwm_wr_q <= pwm_wr_nxt;
      cmp_q    <= cmp_nxt;
      div_wr_q <= div_wr_nxt;
      div_in_q <= div_in_nxt;
    end
  end

  assign bus.pwm_wr      = pwm_wr_q;
  assign bus.pwm_compare = cmp_q;
  assign bus.clk_div_wr  = div_wr_q;
  assign bus.clk_div_in  = div_in_q;
  assign bus.sync_mode   = sync_q;
  assign bus.busy        = ~fifo_empty | (state != ST_IDLE);
  assign bus.cmd_drop    = drop_q;
  assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Directed bench for pwm_cmd_sequencer: single writes, divider write,
// broadcast, sync mode, queue overflow, bad address and reset abort.
module tb_pwm_cmd_sequencer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pwm_cmd_sequencer_if bus ();

  pwm_cmd_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // One rising edge on cmd_valid carrying a word; returns one cycle later.
  task automatic applyStimulus(input logic [15:0] word);
    bus.cmd_data  = word;
    bus.cmd_valid = 1'b1;
    step_cycle();
    bus.cmd_valid = 1'b0;
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    logic [7:0] exp_ch;
    tests_run        = 0;
    tests_failed     = 0;
    rst              = 1'b1;
    bus.cmd_data     = '0;
    bus.cmd_valid    = 1'b0;
    bus.period_tick  = 1'b0;
    repeat (3) step_cycle();

    checkOutput("rst_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    checkOutput("rst_compare", 32'(bus.pwm_compare), 32'h0);
    checkOutput("rst_div_wr", 32'(bus.clk_div_wr), 32'h0);
    checkOutput("rst_sync", 32'(bus.sync_mode), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_drop_err", 32'({bus.cmd_drop, bus.cmd_err}), 32'h0);
    rst = 1'b0;
    step_cycle();

    // Single channel write, N+3 latency, one cycle wide.
    applyStimulus(16'h3155);
    checkOutput("t1_n1_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    step_cycle();
    checkOutput("t1_n2_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    step_cycle();
    checkOutput("t1_n3_pwm_wr", 32'(bus.pwm_wr), 32'h08);
    checkOutput("t1_n3_compare", 32'(bus.pwm_compare), 32'h155);
    checkOutput("t1_n3_div_wr", 32'(bus.clk_div_wr), 32'h0);
    step_cycle();
    checkOutput("t1_n4_pwm_wr", 32'(bus.pwm_wr), 32'h0);

    // Clock divider write.
    applyStimulus(16'h8007);
    step_cycle();
    step_cycle();
    checkOutput("t2_div_wr", 32'(bus.clk_div_wr), 32'h1);
    checkOutput("t2_div_in", 32'(bus.clk_div_in), 32'h7);
    checkOutput("t2_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    step_cycle();
    checkOutput("t2_div_wr_off", 32'(bus.clk_div_wr), 32'h0);

    // Broadcast walks one strobe across all channels.
    applyStimulus(16'h9200);
    step_cycle();
    checkOutput("t3_busy", 32'(bus.busy), 32'h1);
    step_cycle();
    checkOutput("t3_ch0", 32'(bus.pwm_wr), 32'h01);
    checkOutput("t3_compare", 32'(bus.pwm_compare), 32'h200);
    for (int i = 1; i < 8; i++) begin
      step_cycle();
      exp_ch = 8'h01 << i;
      checkOutput("t3_chn", 32'(bus.pwm_wr), 32'(exp_ch));
    end
    step_cycle();
    checkOutput("t3_end_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    checkOutput("t3_end_busy", 32'(bus.busy), 32'h0);

    // Sync mode holds a channel write until the period tick.
    applyStimulus(16'hA001);
    step_cycle();
    checkOutput("t4_sync_on", 32'(bus.sync_mode), 32'h1);
    applyStimulus(16'h1010);
    repeat (4) step_cycle();
    checkOutput("t4_held", 32'(bus.pwm_wr), 32'h0);
    checkOutput("t4_busy", 32'(bus.busy), 32'h1);
    bus.period_tick = 1'b1;
    step_cycle();
    bus.period_tick = 1'b0;
    checkOutput("t4_m1", 32'(bus.pwm_wr), 32'h0);
    step_cycle();
    checkOutput("t4_m2_pwm_wr", 32'(bus.pwm_wr), 32'h02);
    checkOutput("t4_m2_compare", 32'(bus.pwm_compare), 32'h010);
    step_cycle();
    checkOutput("t4_m3", 32'(bus.pwm_wr), 32'h0);

    // Fill the queue behind a waiting word; the fifth extra word is dropped.
    applyStimulus(16'h1111);
    step_cycle();
    applyStimulus(16'hA000);
    step_cycle();
    applyStimulus(16'h2022);
    step_cycle();
    applyStimulus(16'h3033);
    step_cycle();
    applyStimulus(16'h4044);
    checkOutput("t5_no_drop", 32'(bus.cmd_drop), 32'h0);
    step_cycle();
    applyStimulus(16'h5055);
    checkOutput("t5_drop", 32'(bus.cmd_drop), 32'h1);
    step_cycle();
    checkOutput("t5_drop_off", 32'(bus.cmd_drop), 32'h0);
    checkOutput("t5_still_held", 32'(bus.pwm_wr), 32'h0);
    bus.period_tick = 1'b1;
    step_cycle();
    bus.period_tick = 1'b0;
    step_cycle();
    checkOutput("t5_first_wr", 32'(bus.pwm_wr), 32'h02);
    checkOutput("t5_first_cmp", 32'(bus.pwm_compare), 32'h111);
    step_cycle();
    checkOutput("t5_sync_off", 32'(bus.sync_mode), 32'h0);
    step_cycle();
    step_cycle();
    checkOutput("t5_second_wr", 32'(bus.pwm_wr), 32'h04);
    checkOutput("t5_second_cmp", 32'(bus.pwm_compare), 32'h022);
    step_cycle();
    step_cycle();
    checkOutput("t5_third_wr", 32'(bus.pwm_wr), 32'h08);
    checkOutput("t5_third_cmp", 32'(bus.pwm_compare), 32'h033);
    step_cycle();
    step_cycle();
    checkOutput("t5_fourth_wr", 32'(bus.pwm_wr), 32'h10);
    checkOutput("t5_fourth_cmp", 32'(bus.pwm_compare), 32'h044);
    step_cycle();
    step_cycle();
    checkOutput("t5_dropped_absent", 32'(bus.pwm_wr), 32'h0);
    checkOutput("t5_idle_busy", 32'(bus.busy), 32'h0);

    // Undefined address pulses cmd_err without any strobe.
    applyStimulus(16'hF000);
    checkOutput("t5_err_n1", 32'(bus.cmd_err), 32'h0);
    step_cycle();
    checkOutput("t5_err_n2", 32'(bus.cmd_err), 32'h1);
    checkOutput("t5_err_strobes", 32'({bus.clk_div_wr, bus.pwm_wr}), 32'h0);
    step_cycle();
    checkOutput("t5_err_off", 32'(bus.cmd_err), 32'h0);

    // Reset in the middle of a broadcast with another word queued.
    applyStimulus(16'h9155);
    step_cycle();
    applyStimulus(16'h0001);
    checkOutput("t6_ch0", 32'(bus.pwm_wr), 32'h01);
    step_cycle();
    step_cycle();
    step_cycle();
    checkOutput("t6_ch3", 32'(bus.pwm_wr), 32'h08);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_pwm_wr", 32'(bus.pwm_wr), 32'h0);
    checkOutput("t6_async_compare", 32'(bus.pwm_compare), 32'h0);
    checkOutput("t6_async_busy", 32'(bus.busy), 32'h0);
    step_cycle();
    rst = 1'b0;
    repeat (4) step_cycle();
    checkOutput("t6_queue_lost", 32'(bus.pwm_wr), 32'h0);
    checkOutput("t6_queue_lost_busy", 32'(bus.busy), 32'h0);
    applyStimulus(16'h7123);
    step_cycle();
    step_cycle();
    checkOutput("t6_post_pwm_wr", 32'(bus.pwm_wr), 32'h80);
    checkOutput("t6_post_compare", 32'(bus.pwm_compare), 32'h123);
    step_cycle();
    checkOutput("t6_post_off", 32'(bus.pwm_wr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
